disp_conv_sched: RTL and testbench

- Shared scale-and-convert engine for the seven-segment display path, with its own sequencing.
- Two requesters are arbitrated round-robin: 0 = CPU result register, 1 = cycle/instruction counter.
- The granted 30-bit value plus overflow flag is optionally scaled by a fixed-point constant using an iterative shift-add multiplier.
- The result is then converted to 10 BCD digits by iterative double-dabble and presented with a one-cycle valid strobe.

---
 rtl/disp_conv_sched_pkg.sv | 12 +
 rtl/disp_conv_sched_if.sv | 27 ++
 rtl/disp_conv_sched_bin2bcd_seq.sv | 51 +++++
 rtl/disp_conv_sched.sv | 118 +++++++++++
 tb/tb_disp_conv_sched.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/disp_conv_sched_pkg.sv
// Shared types and default constants for the display scale-and-convert path.
package disp_pkg;

    typedef enum logic [1:0] {IDLE, MUL, BCD, DONE} state_t;

    localparam logic [31:0] DEF_SCALE  = 32'd2037552085;
    localparam logic [29:0] DEF_THRESH = 30'd950000000;
    localparam int          DEF_NDIG   = 10;
    localparam int          MUL_CYC    = 31;
    localparam int          BCD_CYC    = 30;

endpackage

// File: rtl/disp_conv_sched_if.sv
// Requester/result bundle of the display scale-and-convert engine.
interface disp_conv_sched_if #(
    parameter int W    = 30,
    parameter int NDIG = 10
);
    logic [1:0]        req;
    logic              ovf0;
    logic [W-1:0]      val0;
    logic              ovf1;
    logic [W-1:0]      val1;
    logic [1:0]        ack;
    logic              busy;
    logic              out_valid;
    logic              out_id;
    logic              out_scaled;
    logic [4*NDIG-1:0] out_bcd;

    modport master (
        output req, ovf0, val0, ovf1, val1,
        input  ack, busy, out_valid, out_id, out_scaled, out_bcd
    );

    modport slave (
        input  req, ovf0, val0, ovf1, val1,
        output ack, busy, out_valid, out_id, out_scaled, out_bcd
    );
endinterface

// File: rtl/disp_conv_sched_bin2bcd_seq.sv
// Iterative double-dabble: loads on start, one add-3/shift step per cycle, done pulse after the last step.
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int W    = 30,
    parameter int NDIG = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W-1:0]      din,
    output logic              done,
    output logic [4*NDIG-1:0] bcd
);
    logic [W-1:0]      bin;
    logic [4:0]        cnt;
    logic              run;
    logic [4*NDIG-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin  <= '0;
            bcd  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            bin  <= din;
            bcd  <= '0;
            cnt  <= 5'(BCD_CYC);
            run  <= 1'b1;
            done <= 1'b0;
        end else if (run) begin
            {bcd, bin} <= {adj, bin} << 1;
            cnt        <= cnt - 5'd1;
            if (cnt == 5'd1) begin
                run  <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end
endmodule

// File: rtl/disp_conv_sched.sv
// Round-robin shared engine: optional fixed-point scaling by shift-add, then BCD conversion.
//   state | meaning
//   IDLE  | waiting for a request; accepts and acks the winner
//   MUL   | 31-cycle shift-add multiply of {ovf,val} by SCALE
//   BCD   | double-dabble running in bin2bcd_seq
//   DONE  | result strobe cycle, back to IDLE next
module disp_conv_sched
    import disp_pkg::*;
#(
    parameter int          W      = 30,
    parameter logic [31:0] SCALE  = DEF_SCALE,
    parameter logic [W-1:0] THRESH = DEF_THRESH,
    parameter int          NDIG   = DEF_NDIG
) (
    input  logic              clk,
    input  logic              rst,
    disp_conv_sched_if.slave  bus
);
    localparam int PW = W + 33;

    state_t            state;
    logic              prio;
    logic              job_id;
    logic              job_scaled;
    logic [W:0]        opnd;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     mcand;
    logic [PW-1:0]     acc_nxt;
    logic [4:0]        mul_cnt;
    logic              win;
    logic              ovf_w;
    logic [W-1:0]      val_w;
    logic              scale_w;
    logic              bcd_start;
    logic [W-1:0]      bcd_din;
    logic              bcd_done;
    logic [4*NDIG-1:0] bcd_res;

    // prio=1 means requester 1 wins a tie (it was not granted last)
    always_comb begin
        win       = bus.req[1] & (~bus.req[0] | prio);
        ovf_w     = win ? bus.ovf1 : bus.ovf0;
        val_w     = win ? bus.val1 : bus.val0;
        scale_w   = ovf_w | (val_w >= THRESH);
        acc_nxt   = acc + (opnd[0] ? mcand : '0);
        bcd_start = ((state == IDLE) && (|bus.req) && !scale_w) ||
                    ((state == MUL) && (mul_cnt == 5'd1));
        bcd_din   = (state == MUL) ? acc_nxt[32 +: W] : val_w;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            prio           <= 1'b0;
            job_id         <= 1'b0;
            job_scaled     <= 1'b0;
            opnd           <= '0;
            acc            <= '0;
            mcand          <= '0;
            mul_cnt        <= '0;
            bus.ack        <= '0;
            bus.busy       <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_id     <= 1'b0;
            bus.out_scaled <= 1'b0;
            bus.out_bcd    <= '0;
        end else begin
            bus.ack       <= '0;
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        bus.ack[win] <= 1'b1;
                        bus.busy     <= 1'b1;
                        prio         <= ~win;
                        job_id       <= win;
                        job_scaled   <= scale_w;
                        opnd         <= {ovf_w, val_w};
                        acc          <= '0;
                        mcand        <= PW'(SCALE);
                        mul_cnt      <= 5'(MUL_CYC);
                        state        <= scale_w ? MUL : BCD;
                    end
                end
                MUL: begin
                    acc     <= acc_nxt;
                    mcand   <= mcand << 1;
                    opnd    <= opnd >> 1;
                    mul_cnt <= mul_cnt - 5'd1;
                    if (mul_cnt == 5'd1) state <= BCD;
                end
                BCD: begin
                    if (bcd_done) begin
                        state          <= DONE;
                        bus.out_valid  <= 1'b1;
                        bus.out_bcd    <= bcd_res;
                        bus.out_id     <= job_id;
                        bus.out_scaled <= job_scaled;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    bin2bcd_seq #(.W(W), .NDIG(NDIG)) u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (bcd_start),
        .din   (bcd_din),
        .done  (bcd_done),
        .bcd   (bcd_res)
    );
endmodule

// File: tb/tb_disp_conv_sched.sv
// Directed and randomized bench for disp_conv_sched against a decimal/integer reference model.
module tb_disp_conv_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    logic [39:0] last_bcd;

    disp_conv_sched_if #(.W(30), .NDIG(10)) bus();

    disp_conv_sched #(
        .W(30), .SCALE(32'd2037552085), .THRESH(30'd950000000), .NDIG(10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: scaled result is floor(x*SCALE/2^32), computed with plain 64-bit arithmetic
    function automatic logic [29:0] ref_val(input logic ovf, input logic [29:0] v, output logic sc);
        longint unsigned x;
        x  = {33'd0, ovf, v};
        sc = ovf || (v >= 30'd950000000);
        if (sc) x = (x * 64'd2037552085) >> 32;
        return x[29:0];
    endfunction

    function automatic logic [39:0] to_bcd(input longint unsigned x);
        logic [39:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic run_job(input int id, input logic ovf, input logic [29:0] v, input bit mutate);
        logic sc;
        logic [29:0] r;
        int n;
        bit got;
        r = ref_val(ovf, v, sc);
        if (id == 0) begin bus.ovf0 = ovf; bus.val0 = v; end
        else         begin bus.ovf1 = ovf; bus.val1 = v; end
        bus.req[id] = 1'b1;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.ack != 2'b00) got = 1;
        end
        chk("ack_onehot", 64'(bus.ack), 64'(2'b01 << id));
        bus.req[id] = 1'b0;
        if (mutate) begin
            if (id == 0) begin bus.ovf0 = ~ovf; bus.val0 = ~v; end
            else         begin bus.ovf1 = ~ovf; bus.val1 = ~v; end
        end
        n = 0;
        got = 0;
        for (int i = 0; i < 150 && !got; i++) begin
            @(posedge clk); #1;
            n++;
            if (bus.ack != 2'b00) chk("ack_while_busy", 64'(bus.ack), 64'd0);
            if (bus.out_valid) got = 1;
        end
        chk("valid_seen", 64'(got), 64'd1);
        chk("latency", 64'(n), sc ? 64'd62 : 64'd31);
        chk("out_bcd", 64'(bus.out_bcd), 64'(to_bcd(64'(r))));
        chk("out_id", 64'(bus.out_id), 64'(id));
        chk("out_scaled", 64'(bus.out_scaled), 64'(sc));
        last_bcd = bus.out_bcd;
        @(posedge clk); #1;
        chk("valid_pulse", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        logic sc0, sc1;
        logic [29:0] r0, r1, rv;
        int acks_seen, last_valid_cyc, exp_grant, cur_id;
        bit finished;

        bus.req = 2'b00; bus.ovf0 = 1'b0; bus.val0 = '0; bus.ovf1 = 1'b0; bus.val1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ack", 64'(bus.ack), 64'd0);
        chk("rst_bcd", 64'(bus.out_bcd), 64'd0);
        @(negedge clk) rst = 1'b1;

        run_job(0, 1'b0, 30'd12345, 0);
        chk("lit_12345", 64'(last_bcd), 64'h0000012345);
        run_job(0, 1'b0, 30'd949999999, 0);
        chk("lit_949999999", 64'(last_bcd), 64'h0949999999);
        run_job(0, 1'b0, 30'd950000000, 0);
        chk("lit_950000000", 64'(last_bcd), 64'h0450684335);
        run_job(1, 1'b1, 30'd0, 0);
        chk("lit_ovf1", 64'(last_bcd), 64'h0509388021);
        run_job(0, 1'b0, 30'd777, 1);
        run_job(1, 1'b1, 30'd5, 1);

        for (int k = 0; k < 8; k++) begin
            logic [29:0] v;
            case ($urandom_range(0, 2))
                0:       v = 30'($urandom);
                1:       v = 30'd950000000 - 30'($urandom_range(0, 3)) + 30'($urandom_range(0, 3));
                default: v = 30'($urandom_range(0, 999999));
            endcase
            run_job(int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), v, bit'($urandom_range(0, 1)));
        end

        // Both requests held from reset: grants alternate 0,1,0
        @(posedge clk); #1;
        rst = 1'b0;
        bus.ovf0 = 1'b0; bus.val0 = 30'd123456789;
        bus.ovf1 = 1'b0; bus.val1 = 30'd999999999;
        bus.req  = 2'b11;
        r0 = ref_val(1'b0, 30'd123456789, sc0);
        r1 = ref_val(1'b0, 30'd999999999, sc1);
        @(negedge clk) rst = 1'b1;
        acks_seen = 0; last_valid_cyc = -1; exp_grant = 0; cur_id = 0; finished = 0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(posedge clk); #1;
            if (bus.ack != 2'b00) begin
                chk("arb_grant", 64'(bus.ack), 64'(2'b01 << exp_grant));
                if (last_valid_cyc >= 0) chk("arb_gap", 64'(cyc - last_valid_cyc), 64'd2);
                cur_id = exp_grant;
                exp_grant ^= 1;
                acks_seen++;
                if (acks_seen == 3) bus.req = 2'b00;
            end
            if (bus.out_valid) begin
                chk("arb_id", 64'(bus.out_id), 64'(cur_id));
                chk("arb_bcd", 64'(bus.out_bcd), 64'(to_bcd(64'(cur_id == 1 ? r1 : r0))));
                chk("arb_scaled", 64'(bus.out_scaled), 64'(cur_id == 1 ? sc1 : sc0));
                last_valid_cyc = cyc;
                if (acks_seen == 3) finished = 1;
            end
        end
        chk("arb_complete", 64'(finished), 64'd1);

        // Reset during MUL aborts the job
        @(posedge clk); #1;
        bus.ovf0 = 1'b0; bus.val0 = 30'd960000000; bus.req = 2'b01;
        finished = 0;
        for (int i = 0; i < 50 && !finished; i++) begin
            @(posedge clk); #1;
            if (bus.ack != 2'b00) finished = 1;
        end
        chk("mid_ack", 64'(bus.ack), 64'd1);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req = 2'b00;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_bcd", 64'(bus.out_bcd), 64'd0);
        chk("abort_id", 64'(bus.out_id | bus.out_scaled), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("abort_no_valid", 64'(bus.out_valid), 64'd0);
        end
        @(negedge clk) rst = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            chk("abort_stays_quiet", 64'(bus.out_valid), 64'd0);
        end
        rv = ref_val(1'b0, 30'd960000000, sc0);
        run_job(0, 1'b0, 30'd960000000, 0);
        chk("rerequest_bcd", 64'(last_bcd), 64'(to_bcd(64'(rv))));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
